// File: rtl/wb_pkg.sv
// Shared types and default sizing for the register-file writeback path.
package wb_pkg;

  localparam int WB_AW     = 5;
  localparam int WB_DW     = 32;
  localparam int WB_QDEPTH = 4;

  // One pending register-file write: destination register and value.
  typedef struct packed {
    logic [WB_AW-1:0] rd;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for buffered ALU results. The head entry is read
// combinationally so it can be selected and popped in the same cycle.
// DEPTH must be a power of two so the pointers wrap without extra logic.
import wb_pkg::*;

module wb_fifo #(
  parameter type T     = wb_entry_t,
  parameter int  DEPTH = WB_QDEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [PW:0]    cnt_q;

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port arbiter. Load responses always win the port;
// ALU results bypass when the queue is empty, otherwise they wait in a FIFO.
// Also tracks outstanding loads per register for decode hazard stalls.
// Optional feature macro: WB_ORDER_CHECK_EN (sticky protocol error flag).
import wb_pkg::*;

module writeback_unit #(
  parameter int AW     = WB_AW,
  parameter int DW     = WB_DW,
  parameter int QDEPTH = WB_QDEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [AW-1:0]    alu_rd,
  input  logic [DW-1:0]    alu_data,
  input  logic             ld_issue,
  input  logic [AW-1:0]    ld_issue_rd,
  input  logic             ld_rsp_valid,
  input  logic [AW-1:0]    ld_rsp_rd,
  input  logic [DW-1:0]    ld_rsp_data,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [DW-1:0]    wr_data,
  output logic [2**AW-1:0] pending,
  output logic             busy,
  output logic             err
);

  localparam int NREG = 2**AW;
  localparam int CW   = $clog2(QDEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  entry_t          alu_entry;
  entry_t          head;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic            alu_xfer;
  logic            push;
  logic            pop;
  logic            sel_valid;
  logic [AW-1:0]   sel_rd;
  logic [DW-1:0]   sel_data;

  logic            wr_en_q,   wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [NREG-1:0] pending_q, pending_d;

  assign alu_entry = '{rd: alu_rd, data: alu_data};
  // Ready looks only at registered occupancy, so a same-cycle pop never
  // opens a slot in a full queue.
  assign alu_ready = !full;
  assign alu_xfer  = alu_valid && !full;

  wb_fifo #(
    .T     (entry_t),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (alu_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Port arbitration: load response, then queue head, then ALU bypass.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    push      = 1'b0;
    pop       = 1'b0;
    if (ld_rsp_valid) begin
      sel_valid = 1'b1;
      sel_rd    = ld_rsp_rd;
      sel_data  = ld_rsp_data;
      push      = alu_xfer;
    end else if (!empty) begin
      sel_valid = 1'b1;
      sel_rd    = head.rd;
      sel_data  = head.data;
      pop       = 1'b1;
      push      = alu_xfer;
    end else if (alu_xfer) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end
    // x0 slots are consumed but never produce a write strobe.
    wr_en_d   = sel_valid && (sel_rd != '0);
    wr_addr_d = sel_valid ? sel_rd   : wr_addr_q;
    wr_data_d = sel_valid ? sel_data : wr_data_q;
  end

  // Scoreboard next state: response clears, issue sets; set applied last so it wins.
  always_comb begin
    pending_d = pending_q;
    if (ld_rsp_valid) begin
      pending_d[ld_rsp_rd] = 1'b0;
    end
    if (ld_issue && (ld_issue_rd != '0)) begin
      pending_d[ld_issue_rd] = 1'b1;
    end
  end

  // Output registers and scoreboard state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pending_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pending_q <= pending_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign pending = pending_q;
  assign busy    = (count != '0) || (|pending_q);

`ifdef WB_ORDER_CHECK_EN
  logic err_q, err_d;

  // Flag responses without a matching issue, double issues, and ALU writes
  // racing an outstanding load; x0 is exempt.
  always_comb begin
    err_d = err_q;
    if (ld_rsp_valid && (ld_rsp_rd != '0) && !pending_q[ld_rsp_rd])  err_d = 1'b1;
    if (ld_issue && (ld_issue_rd != '0) && pending_q[ld_issue_rd])    err_d = 1'b1;
    if (alu_xfer && (alu_rd != '0) && pending_q[alu_rd])              err_d = 1'b1;
  end

  // Sticky error register.
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: scoreboard of expected writes,
// one task per scenario.
`timescale 1ns/1ps
module tb_writeback_unit;

  localparam int AW = 5;
  localparam int DW = 32;
`ifdef WB_ORDER_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             alu_valid;
  logic             alu_ready;
  logic [AW-1:0]    alu_rd;
  logic [DW-1:0]    alu_data;
  logic             ld_issue;
  logic [AW-1:0]    ld_issue_rd;
  logic             ld_rsp_valid;
  logic [AW-1:0]    ld_rsp_rd;
  logic [DW-1:0]    ld_rsp_data;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [2**AW-1:0] pending;
  logic             busy;
  logic             err;

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];

  writeback_unit #(.AW(AW), .DW(DW), .QDEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .ld_issue     (ld_issue),
    .ld_issue_rd  (ld_issue_rd),
    .ld_rsp_valid (ld_rsp_valid),
    .ld_rsp_rd    (ld_rsp_rd),
    .ld_rsp_data  (ld_rsp_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pending      (pending),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // Advance one clock, then compare any write strobe against the scoreboard.
  task automatic step();
    logic [AW+DW-1:0] e;
    @(posedge clk);
    #1;
    if (wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got x%0d=%h expected none", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL write_order got x%0d=%h expected x%0d=%h",
                   wr_addr, wr_data, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    ld_issue = 0; ld_issue_rd = '0;
    ld_rsp_valid = 0; ld_rsp_rd = '0; ld_rsp_data = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    checks++;
    if ({wr_en, pending, busy, alu_ready, err} !== {1'b0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset got wr_en=%b pending=%h busy=%b ready=%b err=%b expected 0 0 0 1 0",
               wr_en, pending, busy, alu_ready, err);
    end
  endtask

  task automatic test_bypass();
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    step();
    idle();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5) begin
      errors++;
      $display("FAIL bypass_latency got wr_en=%b addr=%0d expected 1 5", wr_en, wr_addr);
    end
    step();
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL bypass_idle got wr_en=%b expected 0", wr_en);
    end
  endtask

  task automatic test_priority();
    ld_issue = 1; ld_issue_rd = 5'd7;
    step();
    idle();
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h11;
    ld_rsp_valid = 1; ld_rsp_rd = 5'd7; ld_rsp_data = 32'h22;
    exp_q.push_back({5'd7, 32'h22});
    exp_q.push_back({5'd3, 32'h11});
    step();
    idle();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'h22) begin
      errors++;
      $display("FAIL prio_load got en=%b x%0d=%h expected 1 x7=22", wr_en, wr_addr, wr_data);
    end
    step();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'h11) begin
      errors++;
      $display("FAIL prio_alu got en=%b x%0d=%h expected 1 x3=11", wr_en, wr_addr, wr_data);
    end
    step();
  endtask

  task automatic test_full();
    logic [AW+DW-1:0] acc[$];
    for (int i = 0; i < 6; i++) begin
      ld_issue = 1; ld_issue_rd = AW'(20 + i);
      step();
    end
    idle();
    for (int i = 0; i < 6; i++) begin
      ld_rsp_valid = 1; ld_rsp_rd = AW'(20 + i); ld_rsp_data = DW'(32'h100 + i);
      alu_valid = 1; alu_rd = AW'(10 + i); alu_data = DW'(32'hA00 + i);
      checks++;
      if (alu_ready !== (i < 4)) begin
        errors++;
        $display("FAIL full_ready cycle %0d got %b expected %b", i, alu_ready, (i < 4));
      end
      if (alu_ready === 1'b1) acc.push_back({alu_rd, alu_data});
      exp_q.push_back({ld_rsp_rd, ld_rsp_data});
      step();
    end
    idle();
    checks++;
    if (acc.size() != 4) begin
      errors++;
      $display("FAIL full_accepted got %0d expected 4", acc.size());
    end
    foreach (acc[k]) exp_q.push_back(acc[k]);
    repeat (6) step();
    checks++;
    if (exp_q.size() != 0 || wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_drain got left=%0d wr_en=%b busy=%b expected 0 0 0",
               exp_q.size(), wr_en, busy);
    end
  endtask

  task automatic test_scoreboard();
    ld_issue = 1; ld_issue_rd = 5'd9;
    step();
    idle();
    checks++;
    if (pending !== 32'h0000_0200 || busy !== 1'b1) begin
      errors++;
      $display("FAIL sb_set got pending=%h busy=%b expected 00000200 1", pending, busy);
    end
    ld_issue = 1; ld_issue_rd = 5'd0;
    step();
    idle();
    checks++;
    if (pending !== 32'h0000_0200) begin
      errors++;
      $display("FAIL sb_x0 got pending=%h expected 00000200", pending);
    end
    ld_rsp_valid = 1; ld_rsp_rd = 5'd9; ld_rsp_data = 32'h99;
    exp_q.push_back({5'd9, 32'h99});
    step();
    idle();
    checks++;
    if (pending !== 32'h0) begin
      errors++;
      $display("FAIL sb_clear got pending=%h expected 0", pending);
    end
  endtask

  task automatic test_alu_x0();
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h1234;
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_ready got %b expected 1", alu_ready);
    end
    step();
    idle();
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL x0_write got wr_en=%b busy=%b expected 0 0", wr_en, busy);
    end
  endtask

  task automatic test_order_check();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clean got %b expected 0", err);
    end
    ld_rsp_valid = 1; ld_rsp_rd = 5'd12; ld_rsp_data = 32'h55;
    exp_q.push_back({5'd12, 32'h55});
    step();
    idle();
    repeat (3) step();
    checks++;
    if (err !== ERR_EXP) begin
      errors++;
      $display("FAIL err_sticky got %b expected %b", err, ERR_EXP);
    end
  endtask

  task automatic test_set_wins();
    ld_issue = 1; ld_issue_rd = 5'd13;
    step();
    ld_rsp_valid = 1; ld_rsp_rd = 5'd13; ld_rsp_data = 32'h77;
    exp_q.push_back({5'd13, 32'h77});
    step();
    idle();
    checks++;
    if (pending[13] !== 1'b1) begin
      errors++;
      $display("FAIL set_wins got pending[13]=%b expected 1", pending[13]);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 2; i++) begin
      ld_rsp_valid = 1; ld_rsp_rd = 5'd13; ld_rsp_data = DW'(32'hC0 + i);
      alu_valid = 1; alu_rd = AW'(16 + i); alu_data = DW'(32'hD0 + i);
      exp_q.push_back({ld_rsp_rd, ld_rsp_data});
      step();
    end
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
    checks++;
    if ({wr_en, pending, busy, alu_ready, err} !== {1'b0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset got wr_en=%b pending=%h busy=%b ready=%b err=%b expected 0 0 0 1 0",
               wr_en, pending, busy, alu_ready, err);
    end
    repeat (4) step();
    checks++;
    if (exp_q.size() != 0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_drop got left=%0d wr_en=%b expected 0 0", exp_q.size(), wr_en);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_priority();
    test_full();
    test_scoreboard();
    test_alu_x0();
    test_order_check();
    test_set_wins();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
